// File: rtl/hsv_frame_ctrl.sv
// Frame-synchronous sequencer for the rgb2hsv converter: gates conv_ce on frame
// boundaries, flushes the pipeline on stop, and measures frame geometry.
module hsv_frame_ctrl #(
    parameter int LATENCY   = 4,
    parameter int CNT_W     = 12,
    parameter int FRAME_W   = 16,
    parameter bit VS_ACTIVE = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable_req,
    input  logic               in_hsync,
    input  logic               in_vsync,
    input  logic               in_de,
    input  logic               err_clr,
    output logic               conv_ce,
    output logic               busy,
    output logic [FRAME_W-1:0] frame_cnt,
    output logic [CNT_W-1:0]   width,
    output logic [CNT_W-1:0]   height,
    output logic               geom_err
);

    typedef enum logic [1:0] {IDLE, WAIT_FS, RUN, DRAIN} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state, next_state;
    logic [7:0]       flush_cnt, next_flush;
    logic             vs_q, de_q, hsync_unused;
    logic [CNT_W-1:0] pix_cnt, line_cnt, line_inc;
    logic             fs, fe, le;

    assign fs       = (vs_q == VS_ACTIVE) && (in_vsync != VS_ACTIVE);
    assign fe       = (vs_q != VS_ACTIVE) && (in_vsync == VS_ACTIVE);
    assign le       = de_q && !in_de;
    assign line_inc = (line_cnt == CNT_MAX) ? line_cnt : line_cnt + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            vs_q         <= ~VS_ACTIVE;
            de_q         <= 1'b0;
            hsync_unused <= 1'b0;
        end else begin
            vs_q         <= in_vsync;
            de_q         <= in_de;
            hsync_unused <= in_hsync;
        end
    end

    // Geometry runs in every state so width/height are valid before the first RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            pix_cnt  <= '0;
            line_cnt <= '0;
            width    <= '0;
            height   <= '0;
            geom_err <= 1'b0;
        end else begin
            if (le)
                pix_cnt <= '0;
            else if (in_de && pix_cnt != CNT_MAX)
                pix_cnt <= pix_cnt + CNT_W'(1);

            if (le)
                width <= pix_cnt;

            if (fe)
                line_cnt <= '0;
            else if (le)
                line_cnt <= line_inc;

            // A line ending on the same edge as the frame is counted in this frame.
            if (fe)
                height <= le ? line_inc : line_cnt;

            if (le && line_cnt != '0 && pix_cnt != width)
                geom_err <= 1'b1;
            else if (err_clr)
                geom_err <= 1'b0;
        end
    end

    always_comb begin
        next_state = state;
        next_flush = flush_cnt;
        case (state)
            IDLE: begin
                if (enable_req)
                    next_state = WAIT_FS;
            end
            WAIT_FS: begin
                if (!enable_req)
                    next_state = IDLE;
                else if (fs)
                    next_state = RUN;
            end
            RUN: begin
                if (fe && !enable_req) begin
                    next_state = DRAIN;
                    next_flush = 8'(LATENCY);
                end
            end
            DRAIN: begin
                if (flush_cnt <= 8'd1) begin
                    next_state = IDLE;
                    next_flush = 8'd0;
                end else begin
                    next_flush = flush_cnt - 8'd1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // conv_ce/busy are registered from next_state so they change on the deciding edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            flush_cnt <= 8'd0;
            conv_ce   <= 1'b0;
            busy      <= 1'b0;
            frame_cnt <= '0;
        end else begin
            state     <= next_state;
            flush_cnt <= next_flush;
            conv_ce   <= (next_state == RUN) || (next_state == DRAIN);
            busy      <= (next_state == RUN) || (next_state == DRAIN);
            if (state == RUN && fe)
                frame_cnt <= frame_cnt + FRAME_W'(1);
        end
    end

endmodule
